// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// alu_rs : integer reservation station with CDB wakeup and dual-lane ALU issue
// Rev 1.0 : initial release
// ============================================================================
module alu_rs #(
  parameter int ENTRIES = 8,
  parameter int XLEN    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [1:0]           disp_valid,
  input  logic [1:0][3:0]      disp_op,
  input  logic [1:0][63:0]     disp_pc,
  input  logic [1:0][7:0]      disp_rd,
  input  logic [1:0][6:0]      disp_rob_tag,
  input  logic [1:0]           disp_rs1_rdy,
  input  logic [1:0]           disp_rs2_rdy,
  input  logic [1:0][7:0]      disp_rs1_tag,
  input  logic [1:0][7:0]      disp_rs2_tag,
  input  logic [1:0][XLEN-1:0] disp_rs1_val,
  input  logic [1:0][XLEN-1:0] disp_rs2_val,
  output logic                 disp_ready,
  input  logic [1:0]           cdb_valid,
  input  logic [1:0][7:0]      cdb_tag,
  input  logic [1:0][XLEN-1:0] cdb_data,
  input  logic [1:0]           issue_ready,
  output logic [1:0]           issue_valid,
  output logic [1:0][3:0]      issue_op,
  output logic [1:0][63:0]     issue_pc,
  output logic [1:0][7:0]      issue_rd,
  output logic [1:0][6:0]      issue_rob_tag,
  output logic [1:0][XLEN-1:0] issue_rs1_val,
  output logic [1:0][XLEN-1:0] issue_rs2_val,
  output logic [1:0][7:0]      issue_rs1_tag,
  output logic [1:0][7:0]      issue_rs2_tag
);
  localparam int IDXW = $clog2(ENTRIES);

  logic [ENTRIES-1:0] ent_valid;
  logic [ENTRIES-1:0] ent_rs1_rdy;
  logic [ENTRIES-1:0] ent_rs2_rdy;
  logic [3:0]         ent_op      [ENTRIES];
  logic [63:0]        ent_pc      [ENTRIES];
  logic [7:0]         ent_rd      [ENTRIES];
  logic [6:0]         ent_rob_tag [ENTRIES];
  logic [7:0]         ent_rs1_tag [ENTRIES];
  logic [7:0]         ent_rs2_tag [ENTRIES];
  logic [XLEN-1:0]    ent_rs1_val [ENTRIES];
  logic [XLEN-1:0]    ent_rs2_val [ENTRIES];

  // Returns {hit, data}; lane 0 has priority on a double match.
  function automatic logic [XLEN:0] snoop(input logic [7:0] tag);
    logic [XLEN:0] r;
    r = '0;
    if (cdb_valid[0] && cdb_tag[0] == tag)
      r = {1'b1, cdb_data[0]};
    else if (cdb_valid[1] && cdb_tag[1] == tag)
      r = {1'b1, cdb_data[1]};
    return r;
  endfunction

  logic [XLEN:0] wake1 [ENTRIES];
  logic [XLEN:0] wake2 [ENTRIES];
  logic [XLEN:0] byp1  [2];
  logic [XLEN:0] byp2  [2];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      wake1[i] = snoop(ent_rs1_tag[i]);
      wake2[i] = snoop(ent_rs2_tag[i]);
    end
    for (int d = 0; d < 2; d++) begin
      byp1[d] = snoop(disp_rs1_tag[d]);
      byp2[d] = snoop(disp_rs2_tag[d]);
    end
  end

  logic [IDXW:0]   free_cnt;
  logic [IDXW-1:0] alloc_idx [2];
  logic [1:0]      alloc_ok;

  always_comb begin
    free_cnt     = '0;
    alloc_ok     = '0;
    alloc_idx[0] = '0;
    alloc_idx[1] = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!ent_valid[i]) begin
        free_cnt = free_cnt + (IDXW+1)'(1);
        if (!alloc_ok[0]) begin
          alloc_ok[0]  = 1'b1;
          alloc_idx[0] = IDXW'(i);
        end else if (!alloc_ok[1]) begin
          alloc_ok[1]  = 1'b1;
          alloc_idx[1] = IDXW'(i);
        end
      end
    end
  end

  assign disp_ready = (free_cnt >= (IDXW+1)'(2));

  logic [ENTRIES-1:0] cand;
  logic [IDXW-1:0]    pick_idx [2];
  logic [1:0]         pick_ok;

  assign cand = ent_valid & ent_rs1_rdy & ent_rs2_rdy;

  always_comb begin
    pick_ok     = '0;
    pick_idx[0] = '0;
    pick_idx[1] = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (cand[i]) begin
        if (!pick_ok[0]) begin
          pick_ok[0]  = 1'b1;
          pick_idx[0] = IDXW'(i);
        end else if (!pick_ok[1]) begin
          pick_ok[1]  = 1'b1;
          pick_idx[1] = IDXW'(i);
        end
      end
    end
  end

  // The oldest-index pick always lands on the lowest-numbered idle lane.
  logic [IDXW-1:0] lane_idx [2];
  logic [1:0]      lane_ok;

  always_comb begin
    lane_ok     = '0;
    lane_idx[0] = pick_idx[0];
    lane_idx[1] = pick_idx[1];
    if (issue_ready[0]) begin
      lane_ok[0] = pick_ok[0];
      lane_ok[1] = issue_ready[1] & pick_ok[1];
    end else begin
      lane_ok[1]  = issue_ready[1] & pick_ok[0];
      lane_idx[1] = pick_idx[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid   <= '0;
      ent_rs1_rdy <= '0;
      ent_rs2_rdy <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_op[i]      <= '0;
        ent_pc[i]      <= '0;
        ent_rd[i]      <= '0;
        ent_rob_tag[i] <= '0;
        ent_rs1_tag[i] <= '0;
        ent_rs2_tag[i] <= '0;
        ent_rs1_val[i] <= '0;
        ent_rs2_val[i] <= '0;
      end
      issue_valid   <= '0;
      issue_op      <= '0;
      issue_pc      <= '0;
      issue_rd      <= '0;
      issue_rob_tag <= '0;
      issue_rs1_val <= '0;
      issue_rs2_val <= '0;
    end else if (flush) begin
      ent_valid   <= '0;
      issue_valid <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (ent_valid[i] && !ent_rs1_rdy[i] && wake1[i][XLEN]) begin
          ent_rs1_rdy[i] <= 1'b1;
          ent_rs1_val[i] <= wake1[i][XLEN-1:0];
        end
        if (ent_valid[i] && !ent_rs2_rdy[i] && wake2[i][XLEN]) begin
          ent_rs2_rdy[i] <= 1'b1;
          ent_rs2_val[i] <= wake2[i][XLEN-1:0];
        end
      end
      for (int l = 0; l < 2; l++) begin
        issue_valid[l] <= lane_ok[l];
        if (lane_ok[l]) begin
          ent_valid[lane_idx[l]] <= 1'b0;
          issue_op[l]            <= ent_op[lane_idx[l]];
          issue_pc[l]            <= ent_pc[lane_idx[l]];
          issue_rd[l]            <= ent_rd[lane_idx[l]];
          issue_rob_tag[l]       <= ent_rob_tag[lane_idx[l]];
          issue_rs1_val[l]       <= ent_rs1_val[lane_idx[l]];
          issue_rs2_val[l]       <= ent_rs2_val[lane_idx[l]];
        end
      end
      // Allocation uses registered valid bits, so slots freed above stay free this cycle.
      for (int d = 0; d < 2; d++) begin
        if (disp_valid[d] && alloc_ok[d]) begin
          ent_valid[alloc_idx[d]]   <= 1'b1;
          ent_op[alloc_idx[d]]      <= disp_op[d];
          ent_pc[alloc_idx[d]]      <= disp_pc[d];
          ent_rd[alloc_idx[d]]      <= disp_rd[d];
          ent_rob_tag[alloc_idx[d]] <= disp_rob_tag[d];
          ent_rs1_tag[alloc_idx[d]] <= disp_rs1_tag[d];
          ent_rs2_tag[alloc_idx[d]] <= disp_rs2_tag[d];
          ent_rs1_rdy[alloc_idx[d]] <= disp_rs1_rdy[d] | byp1[d][XLEN];
          ent_rs2_rdy[alloc_idx[d]] <= disp_rs2_rdy[d] | byp2[d][XLEN];
          ent_rs1_val[alloc_idx[d]] <= disp_rs1_rdy[d] ? disp_rs1_val[d] : byp1[d][XLEN-1:0];
          ent_rs2_val[alloc_idx[d]] <= disp_rs2_rdy[d] ? disp_rs2_val[d] : byp2[d][XLEN-1:0];
        end
      end
    end
  end

  assign issue_rs1_tag = '0;
  assign issue_rs2_tag = '0;

  a_no_disp_when_full: assert property (
    @(posedge clk) disable iff (reset) (|disp_valid) |-> disp_ready
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// tb_alu_rs : scoreboard bench for alu_rs; a slot-level reference model predicts
// every issue and disp_ready, a separate monitor compares what the DUT presents.
module tb_alu_rs;
  localparam int E  = 8;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic reset, flush;
  logic [1:0]         disp_valid, disp_rs1_rdy, disp_rs2_rdy;
  logic [1:0][3:0]    disp_op;
  logic [1:0][63:0]   disp_pc;
  logic [1:0][7:0]    disp_rd, disp_rs1_tag, disp_rs2_tag;
  logic [1:0][6:0]    disp_rob_tag;
  logic [1:0][XL-1:0] disp_rs1_val, disp_rs2_val;
  logic               disp_ready;
  logic [1:0]         cdb_valid;
  logic [1:0][7:0]    cdb_tag;
  logic [1:0][XL-1:0] cdb_data;
  logic [1:0]         issue_ready, issue_valid;
  logic [1:0][3:0]    issue_op;
  logic [1:0][63:0]   issue_pc;
  logic [1:0][7:0]    issue_rd, issue_rs1_tag, issue_rs2_tag;
  logic [1:0][6:0]    issue_rob_tag;
  logic [1:0][XL-1:0] issue_rs1_val, issue_rs2_val;

  always #5 clk = ~clk;

  alu_rs #(.ENTRIES(E), .XLEN(XL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc), .disp_rd(disp_rd),
    .disp_rob_tag(disp_rob_tag), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val), .disp_ready(disp_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_pc(issue_pc), .issue_rd(issue_rd), .issue_rob_tag(issue_rob_tag),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag)
  );

  typedef struct {
    logic [3:0]  op;  logic [63:0] pc;  logic [7:0] rd;  logic [6:0] rob;
    logic r1; logic [7:0] t1; logic [31:0] v1;
    logic r2; logic [7:0] t2; logic [31:0] v2;
  } uop_t;
  typedef struct { int cyc; int lane; uop_t u; } exp_t;

  bit   m_v [E];
  uop_t m_e [E];
  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;
  bit   rdy_next = 1'b1, rdy_cur = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < E; i++) if (!m_v[i]) n++;
    return n;
  endfunction

  function automatic bit cdb_hit(input logic [7:0] t, output logic [31:0] v);
    v = '0;
    if (cdb_valid[0] && cdb_tag[0] == t) begin v = cdb_data[0]; return 1'b1; end
    if (cdb_valid[1] && cdb_tag[1] == t) begin v = cdb_data[1]; return 1'b1; end
    return 1'b0;
  endfunction

  // Advances the model across the upcoming edge using the inputs now applied.
  task automatic model_step();
    int cand[$];
    int fr[$];
    int k;
    logic [31:0] v;
    for (int i = 0; i < E; i++) begin
      if (m_v[i] && m_e[i].r1 && m_e[i].r2) cand.push_back(i);
      if (!m_v[i]) fr.push_back(i);
    end
    if (flush) begin
      for (int i = 0; i < E; i++) m_v[i] = 1'b0;
    end else begin
      k = 0;
      for (int l = 0; l < 2; l++) begin
        if (issue_ready[l] && k < cand.size()) begin
          exp_t e;
          e.cyc = cyc + 1; e.lane = l; e.u = m_e[cand[k]];
          q.push_back(e);
          m_v[cand[k]] = 1'b0;
          k++;
        end
      end
      for (int i = 0; i < E; i++) begin
        if (m_v[i]) begin
          if (!m_e[i].r1 && cdb_hit(m_e[i].t1, v)) begin m_e[i].r1 = 1'b1; m_e[i].v1 = v; end
          if (!m_e[i].r2 && cdb_hit(m_e[i].t2, v)) begin m_e[i].r2 = 1'b1; m_e[i].v2 = v; end
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (disp_valid[d] && fr.size() > d) begin
          uop_t u;
          u.op = disp_op[d]; u.pc = disp_pc[d]; u.rd = disp_rd[d]; u.rob = disp_rob_tag[d];
          u.r1 = disp_rs1_rdy[d]; u.t1 = disp_rs1_tag[d]; u.v1 = disp_rs1_val[d];
          u.r2 = disp_rs2_rdy[d]; u.t2 = disp_rs2_tag[d]; u.v2 = disp_rs2_val[d];
          if (!u.r1 && cdb_hit(u.t1, v)) begin u.r1 = 1'b1; u.v1 = v; end
          if (!u.r2 && cdb_hit(u.t2, v)) begin u.r2 = 1'b1; u.v2 = v; end
          m_e[fr[d]] = u;
          m_v[fr[d]] = 1'b1;
        end
      end
    end
    rdy_next = (m_free() >= 2);
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rdy_cur <= rdy_next;
  end

  exp_t me;
  always @(negedge clk) begin
    if (!reset) begin
      for (int l = 0; l < 2; l++) begin
        if (issue_valid[l]) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_issue lane%0d: got valid expected idle", l);
          end else begin
            me = q.pop_front();
            chk("issue_cycle", 64'(cyc), 64'(me.cyc));
            chk("issue_lane", 64'(l), 64'(me.lane));
            chk("issue_op", issue_op[l], me.u.op);
            chk("issue_pc", issue_pc[l], me.u.pc);
            chk("issue_rd", issue_rd[l], me.u.rd);
            chk("issue_rob", issue_rob_tag[l], me.u.rob);
            chk("issue_rs1", issue_rs1_val[l], me.u.v1);
            chk("issue_rs2", issue_rs2_val[l], me.u.v2);
          end
        end
      end
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        total++; bad++;
        $display("FAIL missing_issue lane%0d: got idle expected issue", q[0].lane);
        void'(q.pop_front());
      end
      chk("disp_ready", disp_ready, rdy_cur);
      chk("issue_tags_zero", {issue_rs1_tag, issue_rs2_tag}, 64'd0);
    end
  end

  task automatic idle_inputs();
    flush = 1'b0; disp_valid = '0; disp_op = '0; disp_pc = '0; disp_rd = '0;
    disp_rob_tag = '0; disp_rs1_rdy = '0; disp_rs2_rdy = '0; disp_rs1_tag = '0;
    disp_rs2_tag = '0; disp_rs1_val = '0; disp_rs2_val = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  function automatic uop_t mk(input logic [3:0] op, input logic [6:0] rob,
                              input bit r1, input logic [7:0] t1, input logic [31:0] v1,
                              input bit r2, input logic [7:0] t2, input logic [31:0] v2);
    uop_t u;
    u.op = op; u.pc = {$urandom, $urandom}; u.rd = 8'($urandom); u.rob = rob;
    u.r1 = r1; u.t1 = t1; u.v1 = v1; u.r2 = r2; u.t2 = t2; u.v2 = v2;
    return u;
  endfunction

  function automatic uop_t rnd_uop();
    return mk(4'($urandom), 7'($urandom),
              1'($urandom), 8'h20 + 8'($urandom_range(0, 15)), $urandom,
              1'($urandom), 8'h20 + 8'($urandom_range(0, 15)), $urandom);
  endfunction

  task automatic set_disp(input int d, input uop_t u);
    disp_valid[d] = 1'b1; disp_op[d] = u.op; disp_pc[d] = u.pc; disp_rd[d] = u.rd;
    disp_rob_tag[d] = u.rob; disp_rs1_rdy[d] = u.r1; disp_rs1_tag[d] = u.t1;
    disp_rs1_val[d] = u.v1; disp_rs2_rdy[d] = u.r2; disp_rs2_tag[d] = u.t2;
    disp_rs2_val[d] = u.v2;
  endtask

  task automatic set_cdb(input int l, input logic [7:0] t, input logic [31:0] dat);
    cdb_valid[l] = 1'b1; cdb_tag[l] = t; cdb_data[l] = dat;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic model_clear();
    for (int i = 0; i < E; i++) m_v[i] = 1'b0;
    q.delete();
    rdy_next = 1'b1;
  endtask

  initial begin
    idle_inputs();
    issue_ready = 2'b11;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_issue_valid", issue_valid, 2'b00);
    chk("rst_disp_ready", disp_ready, 1'b1);
    chk("rst_issue_data", {issue_rs1_val, issue_rob_tag, issue_op}, 64'd0);
    chk("rst_issue_pc", issue_pc[1], 64'd0);
    reset = 1'b0;

    // Single ready ADD on lane 0
    set_disp(0, mk(4'h0, 7'h15, 1, 8'h00, 32'd5, 1, 8'h00, 32'd7));
    step();
    chk("t1_not_early", issue_valid, 2'b00);
    step();
    chk("t1_valid", issue_valid, 2'b01);
    chk("t1_rs1", issue_rs1_val[0], 32'd5);
    chk("t1_rs2", issue_rs2_val[0], 32'd7);
    chk("t1_rob", issue_rob_tag[0], 7'h15);
    step();
    chk("t1_pulse", issue_valid, 2'b00);

    // Wakeup from CDB lane 1
    set_disp(0, mk(4'h1, 7'h22, 0, 8'h21, 32'd0, 1, 8'h00, 32'd3));
    step();
    set_cdb(1, 8'h21, 32'hDEAD);
    step();
    chk("t2_not_early", issue_valid, 2'b00);
    step();
    chk("t2_valid", issue_valid, 2'b01);
    chk("t2_rs1", issue_rs1_val[0], 32'hDEAD);

    // Same-cycle dispatch bypass
    set_disp(0, mk(4'h2, 7'h33, 0, 8'h30, 32'd0, 1, 8'h00, 32'd9));
    set_cdb(0, 8'h30, 32'd42);
    step();
    step();
    chk("t3_valid", issue_valid, 2'b01);
    chk("t3_rs1", issue_rs1_val[0], 32'd42);

    // Fill all entries, then wake three
    issue_ready = 2'b00;
    for (int k = 0; k < 4; k++) begin
      set_disp(0, mk(4'h3, 7'(2*k),   0, 8'h40 + 8'(2*k),   32'd0, 1, 8'h00, 32'd1));
      set_disp(1, mk(4'h4, 7'(2*k+1), 0, 8'h40 + 8'(2*k+1), 32'd0, 1, 8'h00, 32'd2));
      step();
    end
    chk("t4_full", disp_ready, 1'b0);
    issue_ready = 2'b11;
    set_cdb(0, 8'h40, 32'd100);
    set_cdb(1, 8'h41, 32'd101);
    step();
    chk("t4_still_full", disp_ready, 1'b0);
    set_cdb(0, 8'h42, 32'd102);
    step();
    chk("t4_two_issue", issue_valid, 2'b11);
    chk("t4_lane0_rob", issue_rob_tag[0], 7'd0);
    chk("t4_lane1_rob", issue_rob_tag[1], 7'd1);
    chk("t4_ready_again", disp_ready, 1'b1);
    step();
    chk("t4_third", issue_valid, 2'b01);
    chk("t4_third_rob", issue_rob_tag[0], 7'd2);
    chk("t4_third_rs1", issue_rs1_val[0], 32'd102);

    // Flush with five waiting entries and a concurrent ready dispatch
    flush = 1'b1;
    set_disp(0, mk(4'h5, 7'h55, 1, 8'h00, 32'd1, 1, 8'h00, 32'd1));
    step();
    chk("t6_flush_valid", issue_valid, 2'b00);
    chk("t6_flush_ready", disp_ready, 1'b1);
    step();
    chk("t6_no_ghost", issue_valid, 2'b00);

    // Only lane 1 idle
    issue_ready = 2'b00;
    set_disp(0, mk(4'h6, 7'h61, 1, 8'h00, 32'd11, 1, 8'h00, 32'd12));
    set_disp(1, mk(4'h7, 7'h62, 1, 8'h00, 32'd13, 1, 8'h00, 32'd14));
    step();
    issue_ready = 2'b10;
    step();
    chk("t5_lane1_only", issue_valid, 2'b10);
    chk("t5_lane1_rob", issue_rob_tag[1], 7'h61);
    issue_ready = 2'b11;
    step();
    chk("t5_second", issue_valid, 2'b01);
    chk("t5_second_rob", issue_rob_tag[0], 7'h62);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] t;
      issue_ready = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 63) == 0);
      if (m_free() >= 2)
        for (int d = 0; d < 2; d++)
          if ($urandom_range(0, 2) != 0) set_disp(d, rnd_uop());
      if ($urandom_range(0, 1) != 0) set_cdb(0, 8'h20 + 8'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 1) != 0) begin
        t = 8'h20 + 8'($urandom_range(0, 15));
        if (cdb_valid[0] && t == cdb_tag[0]) t = 8'h20 + ((t + 8'd1) & 8'h0F);
        set_cdb(1, t, $urandom);
      end
      step();
    end

    // Drain everything left
    issue_ready = 2'b11;
    for (int k = 0; k < 300 && m_free() != E; k++) begin
      set_cdb(0, 8'h20 + 8'((2*k) % 16), $urandom);
      set_cdb(1, 8'h20 + 8'((2*k+1) % 16), $urandom);
      step();
    end
    chk("drain_empty", 64'(m_free()), 64'(E));
    step();
    step();

    // Asynchronous reset in the middle of an issue
    set_disp(0, mk(4'h8, 7'h71, 1, 8'h00, 32'd21, 1, 8'h00, 32'd22));
    set_disp(1, mk(4'h9, 7'h72, 1, 8'h00, 32'd23, 1, 8'h00, 32'd24));
    step();
    step();
    chk("pre_reset_issue", issue_valid, 2'b11);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    chk("async_rst_valid", issue_valid, 2'b00);
    chk("async_rst_data", issue_rs1_val[0], 32'd0);
    chk("async_rst_ready", disp_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("post_rst_idle", issue_valid, 2'b00);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
